// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - single-issue command sequencer in front of a registered 8-bit ALU
// Reads operands from a 4-entry register file or an immediate, waits out the ALU latency, optionally writes back and returns a response.
module alu_cmd_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int NREG    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_data,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  input  logic [3:0]  alu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_carry,
  output logic [3:0]  rsp_flag,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  rd_q;
  logic        wr_en_q;
  logic [7:0]  regs [NREG];

  logic [2:0]  cmd_op;
  logic [1:0]  cmd_rd;
  logic [1:0]  cmd_rs1;
  logic [1:0]  cmd_rs2;
  logic        cmd_b_imm;
  logic        cmd_wr_en;
  logic        cmd_a_imm;
  logic [7:0]  cmd_imm;
  logic        unused_rsvd;

  assign cmd_op      = cmd_data[23:21];
  assign cmd_rd      = cmd_data[20:19];
  assign cmd_rs1     = cmd_data[18:17];
  assign cmd_rs2     = cmd_data[16:15];
  assign cmd_b_imm   = cmd_data[14];
  assign cmd_wr_en   = cmd_data[13];
  assign cmd_a_imm   = cmd_data[12];
  assign cmd_imm     = cmd_data[7:0];
  assign unused_rsvd = ^cmd_data[11:8];

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_data  = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      rd_q       <= 2'd0;
      wr_en_q    <= 1'b0;
      alu_op     <= 3'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_flag   <= 4'h0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Operands are read here, so any earlier writeback is already visible.
            alu_op  <= cmd_op;
            alu_a   <= cmd_a_imm ? cmd_imm : regs[cmd_rs1];
            alu_b   <= cmd_b_imm ? cmd_imm : regs[cmd_rs2];
            rd_q    <= cmd_rd;
            wr_en_q <= cmd_wr_en;
            cnt     <= 3'(ALU_LAT);
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == 3'd0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_flag   <= alu_flag;
            if (wr_en_q) begin
              regs[rd_q] <= alu_result;
            end
            state <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized and directed self-checking bench for alu_cmd_sequencer
// A behavioural ALU and a register-file model predict every response and writeback.
module tb_alu_cmd_sequencer;

  localparam int LAT = 1;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_data;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic [3:0]  alu_flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_carry;
  logic [3:0]  rsp_flag;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rm [4];
  logic [12:0] pipe [LAT];
  logic [7:0]  r;
  logic        c;

  alu_cmd_sequencer #(.ALU_LAT(LAT), .NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_flag   (alu_flag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_flag   (rsp_flag),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {flag[3:0], carry, result[7:0]}; flag = {zero, sign, carry, parity}.
  function automatic logic [12:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    case (op)
      3'd0:    w = {1'b0, a} + {1'b0, b};
      3'd1:    w = {1'b0, a} - {1'b0, b};
      3'd2:    w = {a, 1'b0};
      3'd3:    w = {a[0], 1'b0, a[7:1]};
      3'd4:    w = {1'b0, a & b};
      3'd5:    w = {1'b0, a | b};
      3'd6:    w = {1'b0, ~a};
      default: w = {1'b0, a};
    endcase
    return {(w[7:0] == 8'h00), w[7], w[8], ^w[7:0], w[8], w[7:0]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= alu_fn(alu_op, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {alu_flag, alu_carry, alu_result} = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                     input logic [1:0] rs2, input logic b_imm, input logic wr,
                                     input logic a_imm, input logic [7:0] imm);
    logic [3:0] rsvd;
    rsvd = 4'($urandom);
    return {op, rd, rs1, rs2, b_imm, wr, a_imm, rsvd, imm};
  endfunction

  task automatic do_cmd(input logic [23:0] cmd, input int hold, output logic [7:0] res, output logic car);
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [12:0] exp;
    int          n;
    ea  = cmd[12] ? cmd[7:0] : rm[cmd[18:17]];
    eb  = cmd[14] ? cmd[7:0] : rm[cmd[16:15]];
    exp = alu_fn(cmd[23:21], ea, eb);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    @(posedge clk); #1;
    // Anything offered while busy must be ignored.
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_data  = 24'($urandom);
    check("alu_op", alu_op, cmd[23:21]);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_latency", n, 1 + LAT);
    if (cmd[13]) rm[cmd[20:19]] = exp[7:0];
    check("rsp_result", rsp_result, exp[7:0]);
    check("rsp_carry", rsp_carry, exp[8]);
    check("rsp_flag", rsp_flag, exp[12:9]);
    check("alu_a_held", alu_a, ea);
    res = rsp_result;
    car = rsp_carry;
    dbg_addr = cmd[20:19];
    #1;
    check("dbg_writeback", dbg_data, rm[cmd[20:19]]);
    rsp_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_result", rsp_result, exp[7:0]);
      check("hold_flag", {rsp_flag, rsp_carry}, exp[12:8]);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_hs_valid", rsp_valid, 1'b0);
    check("post_hs_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = 24'($urandom);
    rsp_ready = 1'b0;
    dbg_addr  = 2'd0;
    for (int i = 0; i < 4; i++) rm[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 19'h0);
    check("rst_rsp", {rsp_result, rsp_carry, rsp_flag}, 13'h0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check("rst_dbg", dbg_data, 8'h00);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd(mk(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h2A), 0, r, c);
    do_cmd(mk(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h9F), 0, r, c);
    do_cmd(mk(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00), 0, r, c);
    check("chain_add", r, 8'hC9);
    dbg_addr = 2'd2; #1;
    check("chain_dbg", dbg_data, 8'hC9);

    do_cmd(mk(3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'hFF), 0, r, c);
    do_cmd(mk(3'd0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h01), 0, r, c);
    check("carry_result", r, 8'h00);
    check("carry_bit", c, 1'b1);
    dbg_addr = 2'd0; #1;
    check("carry_r0_kept", dbg_data, 8'hFF);

    do_cmd(mk(3'd1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00), 5, r, c);

    do_cmd(mk(3'd7, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h0F), 0, r, c);
    do_cmd(mk(3'd6, 2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00), 0, r, c);
    check("raw_first", r, 8'hF0);
    do_cmd(mk(3'd6, 2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00), 0, r, c);
    check("raw_second", r, 8'h0F);

    for (int k = 0; k < 40; k++) begin
      do_cmd(mk(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 8'($urandom)), $urandom_range(0, 3), r, c);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check("rand_regfile", dbg_data, rm[i]);
    end

    cmd_valid = 1'b1;
    cmd_data  = mk(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h55);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rm[i] = 8'h00;
    repeat (5) begin
      check("midrst_no_rsp", rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    dbg_addr = 2'd1; #1;
    check("midrst_r1", dbg_data, 8'h00);

    do_cmd(mk(3'd2, 2'd0, 2'd1, 2'd0, 1'b0, 1'b1, 1'b1, 8'hC3), 1, r, c);
    check("post_reset_shl", r, 8'h86);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
